queue_manager: RTL
==================

# queue_manager

Parametrised bank-queue controller: debounces arrive/depart buttons, tracks queue occupancy up to `DEPTH`, and derives active-teller count from a teller bitmap. It computes the estimated waiting time as ceil(count × `SVC_TIME` / active tellers) with a sequential divider, then converts it to three BCD digits for the seven-segment drivers. It sits between the board inputs and the existing `seg` encoders and replaces the fixed 4-bit counter / ROM / 2-digit path.

## Interface
- `DEPTH`, 15: maximum queue occupancy. Constraint: `DEPTH*SVC_TIME ≤ 999`.
- `TELLER_N`, 3: number of teller enable inputs.
- `SVC_TIME`, 3: time units per person.
- `DEB_TICKS`, 4: consecutive high samples needed to accept a press.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low.
- `tick_en` in 1: one-cycle sample strobe from the slow clock divider.
- `arrive`, `depart` in 1 each: raw push buttons, asynchronous.
- `teller_on` in `TELLER_N`: bitmap of open tellers.
- `alarm_clr` in 1: clears a sticky alarm. Ignored without the macro.
- `count` out `CNT_W`: occupancy. `CNT_W` = clog2(`DEPTH`+1).
- `active` out clog2(`TELLER_N`+1): popcount of `teller_on`, registered.
- `full`, `empty`, `alarm`, `no_teller` out 1 each.
- `wait_time` out `WAIT_W`: binary wait. `WAIT_W` = clog2(`DEPTH*SVC_TIME`+1).
- `wait_ones`, `wait_tens`, `wait_hund` out 4 each: BCD digits.
- `wait_valid` out 1: high when the `wait_*` outputs match the current `count`/`active`.

## Operation
- Inputs `arrive`/`depart` pass through a 2-FF synchroniser each.
  - Debouncer samples only on `tick_en`.
  - It emits a one-clk event pulse when the input has been sampled high `DEB_TICKS` consecutive times after last being sampled low.
  - It fires once per press.
- Counter rules per clk:
  - Arrive only, `count<DEPTH`: increment.
  - Depart only, `count>0`: decrement.
  - Both events in the same cycle: no change, no alarm.
  - Arrive at full, or depart at empty: count holds and an alarm event is raised.
- `full` = (`count==DEPTH`); `empty` = (`count==0`). Both are registered with `count`.
- `active` registered each clk. `no_teller` = (`active==0`).
- Wait FSM states: IDLE, DIV, BCD.
  - Trigger: `count` or `active` differs from the values latched at the last start.
  - IDLE→DIV on trigger: latch num = count×SVC_TIME + active−1 and den = active; drop `wait_valid`.
  - DIV: restoring divider, one quotient bit per cycle, `N_W` cycles. `N_W` = clog2(`DEPTH*SVC_TIME`+`TELLER_N`).
  - BCD: double-dabble, one bit per cycle, `WAIT_W` cycles.
  - BCD→IDLE: register `wait_time` and the digits, set `wait_valid`.
  - A trigger during DIV or BCD aborts and restarts DIV with new operands on the next cycle. Outputs keep their old values; `wait_valid` stays low.
  - If `active==0`, skip DIV/BCD: result is 0, `wait_valid`=1 one cycle after the trigger.

## Timing
- Reset values:
  - `count`=0, `empty`=1, `full`=0, `alarm`=0, `no_teller`=1.
  - `active`=0, `wait_time`=0, all digits 0, `wait_valid`=1, FSM IDLE.
  - Debouncers cleared (counts 0, armed).
- Event to `count` update: 1 clk after the debounce pulse.
- `count` change to `wait_valid` high: 1 (trigger detect) + `N_W` + `WAIT_W` + 1 clks.
  - Defaults: `N_W`=6, `WAIT_W`=6, so 14 clks.
- Non-sticky `alarm`: one-clk pulse per rejected event.
- Reset mid-computation: FSM returns to IDLE on the next edge, outputs take reset values, and no partial result is ever visible.

## Configuration
- Macro: `QUEUE_MANAGER_ALARM_STICKY_EN`.
- Defined: `alarm` latches high on the first rejected event. It stays high until `alarm_clr`=1 on a clk edge, or reset. If `alarm_clr` and a new violation occur in the same cycle, the alarm stays set.
- Undefined: `alarm` is a one-clk pulse per violation and `alarm_clr` is unused.

## Structure
- Package `queue_pkg`: FSM state enum (IDLE, DIV, BCD), the clog2 helper function, and the `CNT_W`/`WAIT_W`/`N_W` width derivations.
- One sub-module `qm_debounce`, holding the synchroniser, tick-gated stable counter and edge pulse. It is instantiated twice, for `arrive` and `depart`.
- Divider and double-dabble stay inline in the FSM.

## Test plan
- Reset, then 3 arrive presses with `DEB_TICKS`=4 and `teller_on`=3'b011.
  - Expect `count`=3, `active`=2.
  - After 14 clks: `wait_time`=5 (ceil 9/2), digits 5/0/0, `wait_valid`=1.
- Glitchy arrive high for 3 ticks then low: no count change. Held for 4 ticks: exactly one increment.
- Fill to 15, then arrive: `count` stays 15, `full`=1, `alarm` pulses one clk. With the macro, `alarm` stays 1 until `alarm_clr`.
- Arrive and depart pulses in the same clk at `count`=7: `count` stays 7, no alarm, no recompute.
- `teller_on`=0 with `count`=4: `no_teller`=1, `wait_time`=0, `wait_valid` one clk after the trigger.
- Change `teller_on` from 3'b111 to 3'b001 mid-DIV with `count`=15.
  - The computation restarts.
  - Final `wait_time`=45, digits 5/4/0, no intermediate value is exposed.

Source files
------------

// File: rtl/queue_pkg.sv
// queue_pkg: shared FSM state type, width helpers and the BCD adjust-and-shift step.
package queue_pkg;

    typedef enum logic [1:0] {IDLE, DIV, BCD} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int wait_w(input int depth, input int svc);
        return clog2(depth * svc + 1);
    endfunction

    function automatic int n_w(input int depth, input int svc, input int tn);
        return clog2(depth * svc + tn);
    endfunction

    // One double-dabble step over three BCD digits: add 3 to digits above 4, then shift in s.
    function automatic logic [11:0] dabble(input logic [11:0] b, input logic s);
        logic [11:0] a;
        a = b;
        for (int i = 0; i < 3; i++)
            if (a[4*i +: 4] > 4'd4) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        return {a[10:0], s};
    endfunction

endpackage

// File: rtl/qm_debounce.sv
// qm_debounce: 2-FF synchroniser plus tick-gated stable-high counter emitting one pulse per press.
module qm_debounce
    import queue_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic tick_en_i,
    input  logic btn_i,
    output logic pulse_o
);
    localparam int DW = clog2(DEB_TICKS + 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q;
    logic          armed_q;
    logic          pulse_q;
    logic          hit;

    assign hit     = armed_q && (cnt_q == DW'(DEB_TICKS - 1));
    assign pulse_o = pulse_q;

    // Once a press fires, disarm until the input is sampled low again.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            pulse_q <= tick_en_i && sync_q[1] && hit;
            if (tick_en_i) begin
                if (!sync_q[1]) begin
                    cnt_q   <= '0;
                    armed_q <= 1'b1;
                end else if (armed_q) begin
                    cnt_q   <= hit ? '0 : cnt_q + DW'(1);
                    armed_q <= !hit;
                end
            end
        end
    end

endmodule

// File: rtl/queue_manager.sv
// queue_manager: debounced queue occupancy, teller count and ceil wait time in binary and BCD.
// Optional QUEUE_MANAGER_ALARM_STICKY_EN makes alarm latch until alarm_clr_i.
module queue_manager
    import queue_pkg::*;
#(
    parameter  int DEPTH     = 15,
    parameter  int TELLER_N  = 3,
    parameter  int SVC_TIME  = 3,
    parameter  int DEB_TICKS = 4,
    localparam int CNT_W     = cnt_w(DEPTH),
    localparam int ACT_W     = clog2(TELLER_N + 1),
    localparam int WAIT_W    = wait_w(DEPTH, SVC_TIME)
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                tick_en_i,
    input  logic                arrive_i,
    input  logic                depart_i,
    input  logic [TELLER_N-1:0] teller_on_i,
    input  logic                alarm_clr_i,
    output logic [CNT_W-1:0]    count_o,
    output logic [ACT_W-1:0]    active_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                alarm_o,
    output logic                no_teller_o,
    output logic [WAIT_W-1:0]   wait_time_o,
    output logic [3:0]          wait_ones_o,
    output logic [3:0]          wait_tens_o,
    output logic [3:0]          wait_hund_o,
    output logic                wait_valid_o
);
    localparam int N_W = n_w(DEPTH, SVC_TIME, TELLER_N);
    localparam int S_W = clog2(N_W + 1);

    logic              arr_ev, dep_ev, alarm_ev, trig, ge;
    logic [CNT_W-1:0]  count_q, count_d, cnt_lat_q;
    logic [ACT_W-1:0]  active_q, active_d, act_lat_q, den_q, rem_q, rem_d;
    logic [ACT_W:0]    rem_sh;
    logic              full_q, empty_q, alarm_q, valid_q;
    state_t            state_q;
    logic [S_W-1:0]    step_q;
    logic [N_W-1:0]    quo_q, quo_d, num_d;
    logic [WAIT_W-1:0] bin_q, wait_q;
    logic [11:0]       bcd_q, dig_q;

    qm_debounce #(.DEB_TICKS(DEB_TICKS)) u_arr (
        .clk_i(clk_i), .reset_ni(reset_ni), .tick_en_i(tick_en_i), .btn_i(arrive_i), .pulse_o(arr_ev)
    );
    qm_debounce #(.DEB_TICKS(DEB_TICKS)) u_dep (
        .clk_i(clk_i), .reset_ni(reset_ni), .tick_en_i(tick_en_i), .btn_i(depart_i), .pulse_o(dep_ev)
    );

`ifndef QUEUE_MANAGER_ALARM_STICKY_EN
    logic unused_alarm_clr;
    assign unused_alarm_clr = alarm_clr_i;
`endif

    always_comb begin
        alarm_ev = (arr_ev && !dep_ev && full_q) || (dep_ev && !arr_ev && empty_q);
        count_d  = (arr_ev && !dep_ev && !full_q)  ? count_q + CNT_W'(1) :
                   (dep_ev && !arr_ev && !empty_q) ? count_q - CNT_W'(1) : count_q;
        active_d = '0;
        for (int i = 0; i < TELLER_N; i++) active_d = active_d + ACT_W'(teller_on_i[i]);
        trig   = (count_q != cnt_lat_q) || (active_q != act_lat_q);
        num_d  = N_W'(count_q) * N_W'(SVC_TIME) + N_W'(active_q) - N_W'(1);
        rem_sh = {rem_q, quo_q[N_W-1]};
        ge     = rem_sh >= {1'b0, den_q};
        rem_d  = ge ? ACT_W'(rem_sh - {1'b0, den_q}) : rem_sh[ACT_W-1:0];
        quo_d  = {quo_q[N_W-2:0], ge};
    end

    // Working registers (quo/rem/bin/bcd) never drive outputs; only the BCD exit commits a result.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            alarm_q   <= 1'b0;
            active_q  <= '0;
            cnt_lat_q <= '0;
            act_lat_q <= '0;
            den_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            step_q    <= '0;
            wait_q    <= '0;
            dig_q     <= '0;
            valid_q   <= 1'b1;
            state_q   <= IDLE;
        end else begin
            count_q  <= count_d;
            full_q   <= count_d == CNT_W'(DEPTH);
            empty_q  <= count_d == '0;
            active_q <= active_d;
`ifdef QUEUE_MANAGER_ALARM_STICKY_EN
            alarm_q  <= alarm_ev || (alarm_q && !alarm_clr_i);
`else
            alarm_q  <= alarm_ev;
`endif
            if (trig) begin
                cnt_lat_q <= count_q;
                act_lat_q <= active_q;
                step_q    <= '0;
                if (active_q == '0) begin
                    wait_q  <= '0;
                    dig_q   <= '0;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    quo_q   <= num_d;
                    rem_q   <= '0;
                    den_q   <= active_q;
                    valid_q <= 1'b0;
                    state_q <= DIV;
                end
            end else begin
                case (state_q)
                    DIV: begin
                        quo_q  <= quo_d;
                        rem_q  <= rem_d;
                        step_q <= step_q + S_W'(1);
                        if (step_q == S_W'(N_W - 1)) begin
                            bin_q   <= quo_d[WAIT_W-1:0];
                            bcd_q   <= '0;
                            step_q  <= '0;
                            state_q <= BCD;
                        end
                    end
                    BCD: begin
                        if (step_q == S_W'(WAIT_W)) begin
                            wait_q  <= quo_q[WAIT_W-1:0];
                            dig_q   <= bcd_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            bcd_q  <= dabble(bcd_q, bin_q[WAIT_W-1]);
                            bin_q  <= bin_q << 1;
                            step_q <= step_q + S_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign count_o      = count_q;
    assign active_o     = active_q;
    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign alarm_o      = alarm_q;
    assign no_teller_o  = active_q == '0;
    assign wait_time_o  = wait_q;
    assign wait_ones_o  = dig_q[3:0];
    assign wait_tens_o  = dig_q[7:4];
    assign wait_hund_o  = dig_q[11:8];
    assign wait_valid_o = valid_q;

endmodule
